// File: rtl/prom_loader_pkg.sv
// prom_loader shared types and constants.
// Optional frame checksum: PROM_LOADER_CHECKSUM_EN.
package prom_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHK
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         LEN_W        = 16;

endpackage

// File: rtl/word_assembler.sv
// Collects WORD_BYTES little-endian bytes into one word.
// Strobes word_valid_o together with the final byte.
module word_assembler #(
  parameter int WORD_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic                    valid_i,
  input  logic [7:0]              byte_i,
  output logic                    word_valid_o,
  output logic [WORD_BYTES*8-1:0] word_o
);

  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORD_BYTES - 1);

  logic [IW-1:0] idx_q, idx_d;

  assign word_valid_o = valid_i && (idx_q == LAST);

  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (valid_i) begin
      idx_d = word_valid_o ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  generate
    if (WORD_BYTES == 1) begin : g_single
      assign word_o = byte_i;
    end else begin : g_multi
      // Holds the earlier bytes; newest byte lands on top.
      logic [WORD_BYTES*8-9:0] shift_q;

      assign word_o = {byte_i, shift_q};

      always_ff @(posedge clk) begin
        if (reset || clear_i) begin
          shift_q <= '0;
        end else if (valid_i) begin
          shift_q <= word_o[WORD_BYTES*8-1:8];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/prom_loader.sv
// Framed UART-to-PROM loader with combinational read port.
// Define PROM_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module prom_loader
  import prom_loader_pkg::*;
#(
  parameter int         WORD_WIDTH = 16,
  parameter int         ROM_WORDS  = 27,
  parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT,
  localparam int        WORD_BYTES = WORD_WIDTH / 8,
  localparam int        AW = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_ready_i,
  output logic                  rx_ack_o,
  input  logic [AW-1:0]         read_addr_i,
  output logic [WORD_WIDTH-1:0] read_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [AW:0]           words_loaded_o
);

  state_e state_q, state_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic [AW:0] words_q, words_d;
  logic [LEN_W-1:0] len_q, len_d;
`ifdef PROM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  logic frame_start;
  logic data_byte;
  logic word_valid;
  logic last_word;
  logic [LEN_W-1:0] len_full;
  logic [WORD_WIDTH-1:0] word;
  logic [WORD_WIDTH-1:0] prom_q [ROM_WORDS];

  assign rx_ack_o    = rx_ready_i;
  assign frame_start = rx_ready_i && (state_q == ST_IDLE)
                       && (rx_data_i == SYNC_BYTE);
  assign data_byte   = rx_ready_i && (state_q == ST_DATA);
  assign len_full    = {rx_data_i, len_q[7:0]};
  assign last_word   = word_valid
                       && ((LEN_W'(words_q) + 16'd1) == len_q);

  word_assembler #(
    .WORD_BYTES(WORD_BYTES)
  ) u_asm (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (frame_start),
    .valid_i     (data_byte),
    .byte_i      (rx_data_i),
    .word_valid_o(word_valid),
    .word_o      (word)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    words_d = words_q;
    len_d   = len_q;
`ifdef PROM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (rx_ready_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            busy_d  = 1'b1;
            done_d  = 1'b0;
            error_d = 1'b0;
            words_d = '0;
`ifdef PROM_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
            state_d = ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          len_d   = {8'h00, rx_data_i};
`ifdef PROM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + rx_data_i;
`endif
          state_d = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          len_d = len_full;
`ifdef PROM_LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_data_i;
`endif
          if (len_full == '0 || len_full > LEN_W'(ROM_WORDS)) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
`ifdef PROM_LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_data_i;
`endif
          if (word_valid) begin
            words_d = words_q + 1'b1;
          end
          if (last_word) begin
`ifdef PROM_LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
`endif
          end
        end
`ifdef PROM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          if (8'(sum_q + rx_data_i) == 8'h00) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
`endif
        default: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      words_q <= '0;
      len_q   <= '0;
`ifdef PROM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      words_q <= words_d;
      len_q   <= len_d;
`ifdef PROM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Contents survive reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (data_byte && word_valid) begin
      prom_q[words_q[AW-1:0]] <= word;
    end
  end

  assign read_data_o = (32'(read_addr_i) < ROM_WORDS)
                       ? prom_q[read_addr_i] : '1;

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_prom_loader.sv
// Directed bench for prom_loader at default parameters.
// Adapts the frame tail to PROM_LOADER_CHECKSUM_EN.
module tb_prom_loader;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready = 1'b0;
  logic          rx_ack;
  logic [AW-1:0] read_addr = '0;
  logic [15:0]   read_data;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q[$];

  prom_loader dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data_i     (rx_data),
    .rx_ready_i    (rx_ready),
    .rx_ack_o      (rx_ack),
    .read_addr_i   (read_addr),
    .read_data_o   (read_data),
    .busy_o        (busy),
    .done_o        (done),
    .error_o       (error),
    .words_loaded_o(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic send_q();
    foreach (q[i]) send(q[i]);
    q.delete();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic rd(input int a);
    read_addr = AW'(a);
    #1;
  endtask

  task automatic test_reset();
    pulse_reset();
    vectors++;
    if ({busy, done, error} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 000", {busy, done, error});
    end
    vectors++;
    if (words_loaded !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_words got %0d want 0", words_loaded);
    end
    rx_data  = 8'hA5;
    rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || rx_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_noready got busy=%b ack=%b want 0 0", busy, rx_ack);
    end
    rx_data  = 8'h3C;
    rx_ready = 1'b1;
    #1;
    vectors++;
    if (rx_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_comb got %b want 1", rx_ack);
    end
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic test_valid_frame();
    send(8'hA5);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_rise got %b want 1", busy);
    end
    q = '{8'h02, 8'h00, 8'h34, 8'h12};
    send_q();
    vectors++;
    if (words_loaded !== 6'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_frame got words=%0d busy=%b want 1 1",
               words_loaded, busy);
    end
    q = '{8'h78, 8'h56};
`ifdef PROM_LOADER_CHECKSUM_EN
    q.push_back(8'hEA);
`endif
    send_q();
    vectors++;
    if ({busy, done, error} !== 3'b010 || words_loaded !== 6'd2) begin
      miscompares++;
      $display("FAIL valid_status got bde=%b words=%0d want 010 2",
               {busy, done, error}, words_loaded);
    end
    rd(0);
    vectors++;
    if (read_data !== 16'h1234) begin
      miscompares++;
      $display("FAIL valid_prom0 got %h want 1234", read_data);
    end
    rd(1);
    vectors++;
    if (read_data !== 16'h5678) begin
      miscompares++;
      $display("FAIL valid_prom1 got %h want 5678", read_data);
    end
  endtask

  task automatic test_bad_checksum();
`ifdef PROM_LOADER_CHECKSUM_EN
    q = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h00};
    send_q();
    vectors++;
    if ({busy, done, error} !== 3'b001) begin
      miscompares++;
      $display("FAIL bad_chk got bde=%b want 001", {busy, done, error});
    end
    rd(0);
    vectors++;
    if (read_data !== 16'h1234) begin
      miscompares++;
      $display("FAIL bad_chk_prom0 got %h want 1234", read_data);
    end
`endif
  endtask

  task automatic test_oversize();
    q = '{8'hA5, 8'h1C, 8'h00};
    send_q();
    vectors++;
    if ({busy, done, error} !== 3'b001 || words_loaded !== 6'd0) begin
      miscompares++;
      $display("FAIL oversize got bde=%b words=%0d want 001 0",
               {busy, done, error}, words_loaded);
    end
    q = '{8'h01, 8'h02};
    send_q();
    vectors++;
    if (busy !== 1'b0 || error !== 1'b1) begin
      miscompares++;
      $display("FAIL oversize_tail got busy=%b err=%b want 0 1", busy, error);
    end
    rd(0);
    vectors++;
    if (read_data !== 16'h1234) begin
      miscompares++;
      $display("FAIL oversize_prom0 got %h want 1234", read_data);
    end
  endtask

  task automatic test_noise_zero_len();
    q = '{8'h00, 8'hFF, 8'h12};
    send_q();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL noise_busy got %b want 0", busy);
    end
    q = '{8'hA5, 8'h00, 8'h00};
    send_q();
    vectors++;
    if ({busy, done, error} !== 3'b001 || words_loaded !== 6'd0) begin
      miscompares++;
      $display("FAIL zero_len got bde=%b words=%0d want 001 0",
               {busy, done, error}, words_loaded);
    end
    q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE};
`ifdef PROM_LOADER_CHECKSUM_EN
    q.push_back(8'h52);
`endif
    send_q();
    vectors++;
    if ({busy, done, error} !== 3'b010) begin
      miscompares++;
      $display("FAIL recover got bde=%b want 010", {busy, done, error});
    end
    rd(0);
    vectors++;
    if (read_data !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL recover_prom0 got %h want beef", read_data);
    end
  endtask

  task automatic test_mid_reset();
    q = '{8'hA5, 8'h01, 8'h00, 8'h34};
    send_q();
    pulse_reset();
    vectors++;
    if ({busy, done, error} !== 3'b000 || words_loaded !== 6'd0) begin
      miscompares++;
      $display("FAIL mid_reset got bde=%b words=%0d want 000 0",
               {busy, done, error}, words_loaded);
    end
    rd(0);
    vectors++;
    if (read_data !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL mid_reset_prom0 got %h want beef", read_data);
    end
    q = '{8'hA5, 8'h01, 8'h00, 8'hCD, 8'hAB};
`ifdef PROM_LOADER_CHECKSUM_EN
    q.push_back(8'h87);
`endif
    send_q();
    rd(0);
    vectors++;
    if (read_data !== 16'hABCD || done !== 1'b1 || words_loaded !== 6'd1) begin
      miscompares++;
      $display("FAIL after_reset got d=%h done=%b words=%0d want abcd 1 1",
               read_data, done, words_loaded);
    end
    rd(1);
    vectors++;
    if (read_data !== 16'h5678) begin
      miscompares++;
      $display("FAIL after_reset_prom1 got %h want 5678", read_data);
    end
  endtask

  task automatic test_full_depth();
    logic [7:0] sum;
    logic [15:0] w;
    q = '{8'hA5, 8'h1B, 8'h00};
    sum = 8'h1B;
    for (int i = 0; i < 27; i++) begin
      w = 16'hC000 + 16'(i);
      q.push_back(w[7:0]);
      q.push_back(w[15:8]);
      sum = sum + w[7:0] + w[15:8];
    end
`ifdef PROM_LOADER_CHECKSUM_EN
    q.push_back(8'(-sum));
`endif
    send_q();
    vectors++;
    if ({busy, done, error} !== 3'b010 || words_loaded !== 6'd27) begin
      miscompares++;
      $display("FAIL full_depth got bde=%b words=%0d want 010 27",
               {busy, done, error}, words_loaded);
    end
    rd(0);
    vectors++;
    if (read_data !== 16'hC000) begin
      miscompares++;
      $display("FAIL full_prom0 got %h want c000", read_data);
    end
    rd(26);
    vectors++;
    if (read_data !== 16'hC01A) begin
      miscompares++;
      $display("FAIL full_prom26 got %h want c01a", read_data);
    end
  endtask

  task automatic test_out_of_range();
    rd(27);
    vectors++;
    if (read_data !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL oor_27 got %h want ffff", read_data);
    end
    rd(31);
    vectors++;
    if (read_data !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL oor_31 got %h want ffff", read_data);
    end
    rd(13);
    vectors++;
    if (read_data !== 16'hC00D) begin
      miscompares++;
      $display("FAIL in_range_13 got %h want c00d", read_data);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_oversize();
    test_noise_zero_len();
    test_mid_reset();
    test_full_depth();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prom_loader.md
# prom_loader

Parametrised, framed UART-to-PROM loader for the CPU instruction store. It consumes bytes from the UART receiver and parses them as a framed image: sync byte, 16-bit word count, little-endian payload, optional checksum. It assembles `WORD_WIDTH`-bit words into an internal PROM array. The array exposes a combinational read port to the CPU fetch path, replacing the fixed two-byte, free-running fill logic.

## Interface
- `WORD_WIDTH`, 16: PROM word width in bits; must be a multiple of 8; `WORD_BYTES = WORD_WIDTH/8`.
- `ROM_WORDS`, 27: PROM depth in words, ≥ 1; `AW = max(1, $clog2(ROM_WORDS))`.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; clears control state, not PROM contents.
- `rx_data_i`  in  8  received byte.
- `rx_ready_i`  in  1  byte valid this cycle.
- `rx_ack_o`  out  1  byte consumed; equals `rx_ready_i` (loader never stalls).
- `read_addr_i`  in  AW  CPU fetch address.
- `read_data_o`  out  WORD_WIDTH  `prom[read_addr_i]`; all-ones if `read_addr_i ≥ ROM_WORDS`.
- `busy_o`  out  1  frame in progress (reset 0).
- `done_o`  out  1  sticky: last frame loaded successfully (reset 0).
- `error_o`  out  1  sticky: last frame rejected (reset 0).
- `words_loaded_o`  out  AW+1  words committed in the current or last frame (reset 0).

## Operation
- A byte is accepted on a rising edge where `rx_ready_i` = 1.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHK.
- IDLE: bytes other than `SYNC_BYTE` are discarded. On `SYNC_BYTE`:
  - clear `done_o`, `error_o` and `words_loaded_o`;
  - set `busy_o`;
  - go to LEN_LO.
- LEN_LO / LEN_HI: capture a 16-bit count N, low byte first.
- Validation after LEN_HI:
  - N = 0 or N > `ROM_WORDS` → set `error_o`, clear `busy_o`, go to IDLE; no writes occur.
  - Otherwise → DATA.
- DATA: bytes shift into an assembly register, little-endian, under a byte index 0..`WORD_BYTES`-1.
  - On the last byte of a word, the full word is written to `prom[word_idx]`, `word_idx` increments, and `words_loaded_o` increments.
  - After word N: go to CHK (macro on) or finish (macro off).
- Finish: clear `busy_o`, set `done_o`, go to IDLE.
- A `SYNC_BYTE` value received mid-frame is treated as data/length; there is no resynchronisation.
- PROM words are written individually as they complete, so a rejected frame leaves earlier words overwritten.
- Reset mid-frame: FSM returns to IDLE, flags and counters clear, already written words persist.

## Timing
- PROM write occurs at the same edge that accepts the final byte of a word. `read_data_o` reflects it from the next cycle onward.
- Reads are combinational, with zero latency.
- `busy_o` rises the cycle after the sync byte is accepted.
- `done_o` / `error_o` are valid the cycle after the terminating byte: CHK byte, last payload byte, or LEN_HI on a length error.
- One byte per cycle is sustained; back-to-back `rx_ready_i` is legal in every state.
- `rx_ack_o` is combinational from `rx_ready_i`.

## Configuration
- `PROM_LOADER_CHECKSUM_EN` defined:
  - One CHK byte follows the payload.
  - Accept only if the mod-256 sum of LEN_LO, LEN_HI, all payload bytes and CHK equals 0.
  - Mismatch → `error_o`, `done_o` stays 0.
- Macro undefined:
  - No CHK state; the frame ends after the last payload byte.
  - `error_o` arises only from length violations.

## Structure
- Shared package `prom_loader_pkg`:
  - FSM state enum;
  - default `SYNC_BYTE`;
  - length field width constant (16).
- One sub-module, `word_assembler`: byte index counter plus shift register. It emits `word_valid` and `word` when `WORD_BYTES` bytes are collected, and is cleared by `reset` or frame start.

## Test plan
Defaults: `WORD_WIDTH`=16, `ROM_WORDS`=27, macro on.
- Valid frame: A5 02 00 34 12 78 56 EA → `prom[0]`=0x1234, `prom[1]`=0x5678, `done_o`=1, `error_o`=0, `words_loaded_o`=2, `busy_o`=0.
- Bad checksum: same frame with CHK=00 → `error_o`=1, `done_o`=0, `prom[0]`=0x1234 (written before rejection).
- Oversize frame: A5 1C 00 (N=28) → `error_o`=1 after LEN_HI, no PROM change. Following bytes 01 02 are ignored until the next A5.
- Noise then zero length: 00 FF 12, then A5 00 00 → noise discarded, `error_o`=1, `words_loaded_o`=0. A subsequent valid frame clears `error_o` and sets `done_o`.
- Mid-frame reset: `reset` pulse after A5 01 00 34 → `busy_o`=0, earlier PROM contents intact. A following valid frame completes correctly.
- Out-of-range read: `read_addr_i`=27 → `read_data_o`=0xFFFF. With macro off, A5 01 00 CD AB → `prom[0]`=0xABCD, `done_o`=1.
